// File: rtl/nbbpu_controller.sv
//------------------------------------------------------------------------------
// nbbpu_controller: multi-cycle fetch/decode/execute/memory/writeback sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module nbbpu_controller #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  output logic        instr_req,
  input  logic        instr_ready,
  input  logic [15:0] instr_data,
  output logic [15:0] instruction,
  input  logic        alu_z0,
  output logic        data_req,
  output logic        data_we,
  input  logic        data_ready,
  output logic        reg_write,
  output logic        pc_enable,
  output logic        pc_select,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);

  localparam int          CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TIMEOUT_U  = 32'(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALT      = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  localparam logic [3:0] OP_JUMP  = 4'h8;
  localparam logic [3:0] OP_BR0   = 4'h9;
  localparam logic [3:0] OP_BR1   = 4'hA;
  localparam logic [3:0] OP_RSVD  = 4'hB;
  localparam logic [3:0] OP_LOAD  = 4'hC;
  localparam logic [3:0] OP_STORE = 4'hD;

  logic [2:0]       state_q,  state_d;
  logic [15:0]      instr_q,  instr_d;
  logic             branch_q, branch_d;
  logic [CNT_W-1:0] wait_q,   wait_d;

  logic [3:0] opcode;
  logic       is_branch;
  logic       is_mem;
  logic       timeout_hit;

  assign opcode    = instr_q[15:12];
  assign is_branch = (opcode == OP_BR0) || (opcode == OP_BR1);
  assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);

  // Fires on the wait cycle that would bring the count up to the limit.
  assign timeout_hit = (TIMEOUT_U != 32'd0) && ((32'(wait_q) + 32'd1) == TIMEOUT_U);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      instr_q  <= 16'h0000;
      branch_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      branch_q <= branch_d;
      wait_q   <= wait_d;
    end
  end

  // Wait counter defaults to zero, so it is already clear on entry to FETCH/MEMORY.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    branch_d = branch_q;
    wait_d   = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (instr_ready) begin
          instr_d = instr_data;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_DECODE: state_d = (opcode == OP_RSVD) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        if (is_branch) begin
          branch_d = alu_z0;
        end
        state_d = is_mem ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        if (data_ready) begin
          state_d = S_WRITEBACK;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    instr_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    reg_write = 1'b0;
    pc_enable = 1'b0;
    pc_select = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state_q)
      S_FETCH: instr_req = 1'b1;
      S_MEMORY: begin
        data_req = 1'b1;
        data_we  = (opcode == OP_STORE);
      end
      S_WRITEBACK: begin
        pc_enable = 1'b1;
        reg_write = !(is_branch || (opcode == OP_STORE));
        pc_select = (opcode == OP_JUMP) || (is_branch && branch_q);
      end
      S_HALT: halted = 1'b1;
      S_FAULT: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instruction = instr_q;

endmodule

`default_nettype wire

// File: doc/nbbpu_controller.md
Name: nbbpu_controller

Overview:
Multi-cycle sequencer for the NBBPU 16-bit core. It fetches each instruction, latches it for the ALU and register file, and steps it through decode, execute, optional memory access and writeback. It drives PC update, register write, and data-memory request/write-enable. It sits between the instruction/data memories and the ALU/register-file datapath, and owns halt and bus-timeout fault handling.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles in FETCH or MEMORY before entering FAULT; 0 disables the timeout.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
instr_req  output  1  instruction fetch request at current PC
instr_ready  input  1  instruction memory has instr_data valid
instr_data  input  16  fetched instruction word
instruction  output  16  latched instruction to ALU/regfile
alu_z0  input  1  ALU Z[0], branch condition
data_req  output  1  data memory access request
data_we  output  1  data memory write enable; store only
data_ready  input  1  data access complete; load data valid
reg_write  output  1  register file write strobe for Z
pc_enable  output  1  PC register load strobe
pc_select  output  1  0 = PC+1, 1 = jump/branch target
halted  output  1  core stopped (HALT or FAULT)
fault  output  1  bus timeout occurred
state  output  3  current FSM state, for debug

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6, FAULT=7.
- Reset (any cycle, including mid-instruction or mid-handshake): next edge gives state=IDLE, instruction=0, branch flag=0, wait counter=0. All outputs are 0 while in IDLE.
- IDLE -> FETCH unconditionally on the first edge after reset is low.
- Outputs are Moore decodes of state plus the latched instruction. Only instruction, branch flag and wait counter are registers.
- FETCH:
  - instr_req=1 and is held until instr_ready is sampled high.
  - On that edge, instruction <= instr_data and the FSM goes to DECODE.
  - instr_ready outside FETCH is ignored.
- DECODE: one cycle for the register-file read.
  - opcode = instruction[15:12].
  - 0xB (reserved) -> HALT; otherwise -> EXECUTE.
- EXECUTE: one cycle. Branch flag <= alu_z0 for opcodes 0x9/0xA.
  - Opcodes 0xC (load) and 0xD (store) -> MEMORY; all others -> WRITEBACK.
- MEMORY:
  - data_req=1; data_we=1 only for 0xD.
  - Held until data_ready is sampled high, then -> WRITEBACK.
  - The memory holds read data stable until the next data_req.
- WRITEBACK: one cycle; pc_enable=1; then -> FETCH.
  - reg_write=1 for opcodes 0x0-0x8, 0xC, 0xE, 0xF; 0 for 0x9, 0xA, 0xD.
  - pc_select=1 for 0x8 always; for 0x9/0xA only when the branch flag is 1; else 0.
- Latency:
  - Non-memory instruction: 4 cycles with zero-wait fetch.
  - Load/store: 5 cycles minimum.
  - Each wait cycle adds 1.
- Timeout:
  - Wait counter clears on entry to FETCH/MEMORY and increments each cycle while ready is low.
  - When the counter reaches TIMEOUT_CYCLES with ready still low -> FAULT.
  - If ready and the timeout occur in the same cycle, ready wins and the normal transition is taken.
- HALT: halted=1, pc_enable=0, no requests; stays until reset.
- FAULT: halted=1, fault=1, no requests; stays until reset.
- No pc_enable or reg_write pulse is ever issued for a halted or faulted instruction.

Test Plan:
- Reset mid-MEMORY: pulse reset while data_req=1 -> next cycle state=0 and all outputs 0; the cycle after reset drops, state=1 and instr_req=1.
- ADD 0x0123 with instr_ready tied high -> instr_req high 1 cycle; DECODE, EXECUTE; WRITEBACK with reg_write=1, pc_enable=1, pc_select=0; next fetch exactly 4 cycles after the first.
- BEQ 0x9xxx with alu_z0=1, then alu_z0=0 -> first: pc_select=1, reg_write=0; second: pc_select=0, pc_enable=1. JUMP 0x8xxx -> pc_select=1, reg_write=1.
- Load 0xC012 with data_ready delayed 3 cycles -> data_req=1, data_we=0 for 4 cycles, then WRITEBACK with reg_write=1. Store 0xD0xx -> data_we=1, reg_write=0.
- Opcode 0xB000 -> HALT after DECODE; halted=1, pc_enable never pulses, instr_req stays 0 for 20 cycles.
- TIMEOUT_CYCLES=4 with instr_ready held low -> FAULT entered after 4 wait cycles, fault=1 and halted=1. Repeat with instr_ready rising on the timeout cycle -> DECODE entered, no fault.
